dump_ctrl: RTL and testbench
============================

DUMP_CTRL -- requirements
Module: dump_ctrl

Interface
REQ-001 Parameter ENTRIES, default 384, SHALL give the sample RAM depth (12288 on DE-0).
REQ-002 Parameter LOG2, default 9, SHALL give the RAM address width.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 dump_req  in  1  one-cycle pulse from cmd_cfg requesting a dump.
REQ-006 dump_chan  in  3  channel to dump; valid with dump_req.
REQ-007 capture_done  in  1  cmd_cfg status bit; dump is permitted only while high.
REQ-008 waddr  in  LOG2  capture write address: the last sample written.
REQ-009 rdata  in  8  RAM read data (externally muxed by chan_sel), valid 1 cycle after ren.
REQ-010 tx_done  in  1  UART pulse: the previous byte has fully shifted out.
REQ-011 ren  out  1  RAM read enable.
REQ-012 raddr  out  LOG2  RAM read address.
REQ-013 chan_sel  out  3  registered channel select driving the RAM read mux.
REQ-014 tx_data  out  8  registered byte presented to the UART.
REQ-015 tx_start  out  1  one-cycle UART transmit strobe.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 dump_done  out  1  one-cycle pulse after the last byte completes; cmd_cfg uses it to clear capture_done.

Function
REQ-018 FSM states SHALL be IDLE, READ, WAIT_RAM, SEND, WAIT_TX.
REQ-019 In IDLE, dump_req with capture_done=1 SHALL be accepted: latch chan_sel<=dump_chan, raddr<=start, byte_cnt<=0, go to READ.
REQ-020 start SHALL be waddr+1, wrapping to 0 when waddr==ENTRIES-1 (oldest sample first).
REQ-021 dump_req with capture_done=0, or dump_req in any non-IDLE state, SHALL be ignored without side effects.
REQ-022 READ: ren=1 for exactly one cycle, then go to WAIT_RAM.
REQ-023 WAIT_RAM: tx_data<=rdata, then go to SEND.
REQ-024 SEND: tx_start=1 for exactly one cycle, then go to WAIT_TX.
REQ-025 WAIT_TX: hold until tx_done. On tx_done with byte_cnt==ENTRIES-1, pulse dump_done and go to IDLE. Otherwise byte_cnt++, raddr++ (wrap ENTRIES-1->0), go to READ.
REQ-026 Latency: dump_req accepted at edge N -> ren high in cycle N+1 -> tx_start high in cycle N+3.
REQ-027 Exactly ENTRIES bytes SHALL be sent per dump; the last address sent SHALL equal waddr.
REQ-028 raddr wrap SHALL compare against ENTRIES-1, not 2^LOG2-1; raddr SHALL never exceed ENTRIES-1.
REQ-029 byte_cnt SHALL be LOG2 bits wide; tx_done outside WAIT_TX SHALL be ignored.
REQ-030 capture_done falling mid-dump SHALL NOT abort the dump.
REQ-031 ren, tx_start and dump_done SHALL be mutually exclusive in any cycle.

Reset
REQ-032 rst SHALL force state IDLE, raddr=0, byte_cnt=0, chan_sel=0, tx_data=0, ren=0, tx_start=0, busy=0, dump_done=0 at the next edge.
REQ-033 rst mid-dump SHALL abort the dump without asserting dump_done; the next accepted dump_req SHALL restart from the first byte.

Structure
REQ-034 The state typedef and the UART byte width constant SHALL live in shared package la_pkg, alongside the capture state type.
REQ-035 The wrapping address counter SHALL be a sub-module, wrap_cnt (parameters ENTRIES/LOG2; ports load, load_val, inc, q).
REQ-036 All outputs SHALL be registered or decoded directly from state; there SHALL be no combinational path from rdata to tx_start.

Verification
REQ-037 Case 1: waddr=100, capture_done=1, dump_req -> 384 bytes from addresses 101..383, 0..100; then one dump_done pulse.
REQ-038 Case 2: waddr=383 -> first raddr is 0 and the last is 383; raddr is never 384.
REQ-039 Case 3: dump_req with capture_done=0 -> busy stays 0; ren and tx_start are never asserted.
REQ-040 Case 4: a second dump_req mid-dump with dump_chan=5 -> ignored; chan_sel keeps the original value.
REQ-041 Case 5: rst at byte 50 -> all outputs take reset values next cycle; no dump_done; a re-request restarts at waddr+1.
REQ-042 Case 6: tx_done delayed by 1000 cycles -> no extra tx_start; exactly one ren per byte; latency dump_req->tx_start is 3 cycles.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser capture and dump path.
package la_pkg;
   localparam int UART_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT_RAM,
      SEND,
      WAIT_TX
   } dump_state_t;

   typedef enum logic [1:0] {
      CAP_IDLE,
      CAP_ARMED,
      CAP_RUN,
      CAP_DONE
   } cap_state_t;
endpackage

// File: rtl/wrap_cnt.sv
// Address counter that wraps at ENTRIES-1 rather than at the power-of-two boundary.
module wrap_cnt #(
   parameter int ENTRIES = 384,
   parameter int LOG2    = 9
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [LOG2-1:0] load_val,
   input  logic            inc,
   output logic [LOG2-1:0] q
);
   localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

   logic [LOG2-1:0] q_q;
   logic [LOG2-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (inc) begin
         q_d = (q_q == LAST) ? '0 : q_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;
endmodule

// File: rtl/dump_ctrl.sv
// Streams one channel of the capture RAM to the UART, oldest sample first,
// one byte per read/transmit handshake.
module dump_ctrl
   import la_pkg::*;
#(
   parameter int ENTRIES = 384,
   parameter int LOG2    = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dump_req,
   input  logic [2:0]        dump_chan,
   input  logic              capture_done,
   input  logic [LOG2-1:0]   waddr,
   input  logic [UART_W-1:0] rdata,
   input  logic              tx_done,
   output logic              ren,
   output logic [LOG2-1:0]   raddr,
   output logic [2:0]        chan_sel,
   output logic [UART_W-1:0] tx_data,
   output logic              tx_start,
   output logic              busy,
   output logic              dump_done
);
   localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

   dump_state_t       state_q, state_d;
   logic [LOG2-1:0]   byte_cnt_q, byte_cnt_d;
   logic [2:0]        chan_sel_q, chan_sel_d;
   logic [UART_W-1:0] tx_data_q, tx_data_d;
   logic              dump_done_q, dump_done_d;
   logic              addr_load;
   logic              addr_inc;
   logic [LOG2-1:0]   start_addr;

   // The slot after the last written sample holds the oldest data.
   assign start_addr = (waddr == LAST) ? '0 : waddr + 1'b1;

   wrap_cnt #(
      .ENTRIES (ENTRIES),
      .LOG2    (LOG2)
   ) u_addr (
      .clk      (clk),
      .rst      (rst),
      .load     (addr_load),
      .load_val (start_addr),
      .inc      (addr_inc),
      .q        (raddr)
   );

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      chan_sel_d  = chan_sel_q;
      tx_data_d   = tx_data_q;
      dump_done_d = 1'b0;
      addr_load   = 1'b0;
      addr_inc    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (dump_req && capture_done) begin
               addr_load  = 1'b1;
               chan_sel_d = dump_chan;
               byte_cnt_d = '0;
               state_d    = READ;
            end
         end
         READ:     state_d = WAIT_RAM;
         WAIT_RAM: begin
            tx_data_d = rdata;
            state_d   = SEND;
         end
         SEND:     state_d = WAIT_TX;
         WAIT_TX: begin
            if (tx_done) begin
               if (byte_cnt_q == LAST) begin
                  dump_done_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  addr_inc   = 1'b1;
                  state_d    = READ;
               end
            end
         end
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         byte_cnt_q  <= '0;
         chan_sel_q  <= '0;
         tx_data_q   <= '0;
         dump_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         chan_sel_q  <= chan_sel_d;
         tx_data_q   <= tx_data_d;
         dump_done_q <= dump_done_d;
      end
   end

   assign ren       = (state_q == READ);
   assign tx_start  = (state_q == SEND);
   assign busy      = (state_q != IDLE);
   assign chan_sel  = chan_sel_q;
   assign tx_data   = tx_data_q;
   assign dump_done = dump_done_q;
endmodule

// File: tb/tb_dump_ctrl.sv
// Scoreboard bench for dump_ctrl: stimulus queues expected bytes, a monitor checks them.
module tb_dump_ctrl;
   localparam int ENTRIES = 384;
   localparam int LOG2    = 9;

   logic            clk = 1'b0;
   logic            rst;
   logic            dump_req;
   logic [2:0]      dump_chan;
   logic            capture_done;
   logic [LOG2-1:0] waddr;
   logic [7:0]      rdata;
   logic            tx_done;
   logic            ren;
   logic [LOG2-1:0] raddr;
   logic [2:0]      chan_sel;
   logic [7:0]      tx_data;
   logic            tx_start;
   logic            busy;
   logic            dump_done;

   dump_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
      .clk          (clk),
      .rst          (rst),
      .dump_req     (dump_req),
      .dump_chan    (dump_chan),
      .capture_done (capture_done),
      .waddr        (waddr),
      .rdata        (rdata),
      .tx_done      (tx_done),
      .ren          (ren),
      .raddr        (raddr),
      .chan_sel     (chan_sel),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .busy         (busy),
      .dump_done    (dump_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         addr;
      int         chan;
      logic [7:0] data;
   } item_t;

   item_t exp_q[$];
   int    pass_cnt = 0;
   int    total_cnt = 0;
   int    sent_cnt = 0;
   int    ren_cnt = 0;
   bit    done_pending = 0;
   bit    done_flag = 0;
   bit    slow_next = 0;

   function automatic logic [7:0] ram_byte(input int ch, input int a);
      return 8'((a * 5 + ch * 29 + 3) & 255);
   endfunction

   task automatic check(input string name, input bit ok, input longint act, input longint exp);
      total_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // RAM model: registered read, one cycle after ren
   always @(posedge clk) begin
      if (ren) rdata <= ram_byte(int'(chan_sel), int'(raddr));
   end

   // UART model: tx_done a few cycles after tx_start, optionally very late
   initial begin
      int d;
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start) begin
            d = slow_next ? 1000 : 2;
            slow_next = 0;
            repeat (d) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
         end
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (ren || tx_start || dump_done)
         check("strobe_exclusive", $onehot0({ren, tx_start, dump_done}),
               longint'({ren, tx_start, dump_done}), 0);
      if (ren) begin
         if (exp_q.size() == 0) begin
            check("ren_unexpected", 1'b0, 1, 0);
         end else begin
            check("raddr", int'(raddr) == exp_q[0].addr, raddr, exp_q[0].addr);
            check("chan_sel", int'(chan_sel) == exp_q[0].chan, chan_sel, exp_q[0].chan);
         end
         ren_cnt++;
      end
      if (tx_start) begin
         if (exp_q.size() == 0) begin
            check("tx_start_unexpected", 1'b0, 1, 0);
         end else begin
            check("ren_per_byte", ren_cnt == 1, ren_cnt, 1);
            check("tx_data", tx_data == exp_q[0].data, tx_data, exp_q[0].data);
            void'(exp_q.pop_front());
            sent_cnt++;
            if (exp_q.size() == 0) done_pending = 1;
         end
         ren_cnt = 0;
      end
      if (dump_done) begin
         check("dump_done_timing", done_pending, 1, 0);
         done_pending = 0;
         done_flag = 1;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ren"}, ren == 1'b0, ren, 0);
      check({tag, "_raddr"}, raddr == '0, raddr, 0);
      check({tag, "_chan_sel"}, chan_sel == '0, chan_sel, 0);
      check({tag, "_tx_data"}, tx_data == '0, tx_data, 0);
      check({tag, "_tx_start"}, tx_start == 1'b0, tx_start, 0);
      check({tag, "_busy"}, busy == 1'b0, busy, 0);
      check({tag, "_dump_done"}, dump_done == 1'b0, dump_done, 0);
   endtask

   // Queue the expected bytes, pulse dump_req and check the ren/tx_start latency.
   task automatic issue_dump(input int wa, input int ch);
      int a;
      done_flag = 0;
      waddr = LOG2'(wa);
      dump_chan = 3'(ch);
      capture_done = 1'b1;
      for (int i = 0; i < ENTRIES; i++) begin
         a = (wa + 1 + i) % ENTRIES;
         exp_q.push_back('{addr: a, chan: ch, data: ram_byte(ch, a)});
      end
      @(negedge clk);
      dump_req = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
      check("latency_ren", ren == 1'b1, ren, 1);
      @(negedge clk);
      @(negedge clk);
      check("latency_tx_start", tx_start == 1'b1, tx_start, 1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done_flag && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("dump_completes", done_flag, done_flag, 1);
      check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
   endtask

   initial begin
      int base;
      int n;
      bit busy_seen;
      rst = 1'b1;
      dump_req = 1'b0;
      dump_chan = '0;
      capture_done = 1'b0;
      waddr = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // tx_done while idle is ignored
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      @(negedge clk);
      check("idle_tx_done_busy", busy == 1'b0, busy, 0);

      // Case 1: waddr=100
      issue_dump(100, 3);
      wait_done();

      // Case 2: waddr=383 wraps to address 0 first
      issue_dump(383, 6);
      wait_done();

      // Case 3: no capture -> request ignored
      capture_done = 1'b0;
      dump_chan = 3'd1;
      waddr = 9'd10;
      busy_seen = 0;
      @(negedge clk);
      dump_req = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
      repeat (10) begin
         if (busy) busy_seen = 1;
         @(negedge clk);
      end
      check("no_capture_busy", busy_seen == 0, busy_seen, 0);

      // Case 4: second request mid-dump is ignored, capture_done drop does not abort
      issue_dump(200, 2);
      repeat (20) @(negedge clk);
      dump_chan = 3'd5;
      waddr = 9'd7;
      dump_req = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
      capture_done = 1'b0;
      check("mid_req_chan_sel", chan_sel == 3'd2, chan_sel, 2);
      check("mid_req_busy", busy == 1'b1, busy, 1);
      wait_done();

      // Case 5: reset at byte 50, then restart from waddr+1
      base = sent_cnt;
      issue_dump(20, 4);
      n = 0;
      while (sent_cnt < base + 50 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("reached_byte_50", sent_cnt >= base + 50, sent_cnt - base, 50);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_reset");
      rst = 1'b0;
      exp_q.delete();
      done_pending = 0;
      ren_cnt = 0;
      repeat (8) @(negedge clk);
      check("no_done_after_abort", done_flag == 0, done_flag, 0);
      issue_dump(20, 4);
      wait_done();

      // Case 6: first byte's tx_done delayed by 1000 cycles
      slow_next = 1;
      issue_dump(50, 1);
      @(negedge clk);
      base = sent_cnt;
      repeat (500) @(negedge clk);
      check("slow_tx_no_extra_start", sent_cnt == base, sent_cnt, base);
      check("slow_tx_busy", busy == 1'b1, busy, 1);
      wait_done();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
